// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared control package for the 5-stage pipeline: opcode constants used by
// the main decoder and the hazard controller, the hazard FSM state encoding,
// and the opcode -> register-use lookup shared with the forwarding unit.
package ctrl_pkg;

  // Opcodes understood by this 8-bit RISC-V core
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // Hazard controller FSM encoding
  localparam logic [0:0] HZ_RUN      = 1'b0;
  localparam logic [0:0] HZ_MEM_WAIT = 1'b1;

  // Which source registers an instruction actually reads
  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
  } reg_use_t;

  // jal reads no register; unknown opcodes are treated as reading nothing so
  // that garbage in ID can never cause a spurious stall.
  function automatic reg_use_t reg_use_lookup(input logic [6:0] opcode);
    reg_use_t ru;
    ru = '0;
    case (opcode)
      OP_RTYPE: ru = '{uses_rs1: 1'b1, uses_rs2: 1'b1};
      OP_SD:    ru = '{uses_rs1: 1'b1, uses_rs2: 1'b1};
      OP_BEQ:   ru = '{uses_rs1: 1'b1, uses_rs2: 1'b1};
      OP_LD:    ru = '{uses_rs1: 1'b1, uses_rs2: 1'b0};
      default:  ru = '0;
    endcase
    return ru;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bus between the pipeline datapath and the hazard controller.
// The datapath side is the master (drives stage info, receives enables and
// flushes); the controller is the slave. Defining HAZARD_PERF_EN adds the
// two performance counter outputs.
interface pipeline_hazard_ctrl_if;

  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;

  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_write;
  logic        id_ex_flush;
  logic        ex_mem_write;
  logic        mem_wb_flush;
  logic        mem_err;
`ifdef HAZARD_PERF_EN
  logic [15:0] perf_stall_cycles;
  logic [15:0] perf_flushes;
`endif

  modport master (
    output id_opcode, id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken,
           mem_req, mem_ready,
`ifdef HAZARD_PERF_EN
    input  perf_stall_cycles, perf_flushes,
`endif
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush, mem_err
  );

  modport slave (
    input  id_opcode, id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken,
           mem_req, mem_ready,
`ifdef HAZARD_PERF_EN
    output perf_stall_cycles, perf_flushes,
`endif
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush, mem_err
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_reg_use.sv
// Combinational opcode -> {uses_rs1, uses_rs2} decoder. Kept as its own
// module so the forwarding unit can instantiate the identical lookup.
module hazard_reg_use
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o
);

  reg_use_t ru;

  // Decode register usage from the shared package lookup
  always_comb begin
    ru         = reg_use_lookup(opcode_i);
    uses_rs1_o = ru.uses_rs1;
    uses_rs2_o = ru.uses_rs2;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// branch/jal squash, and a memory-wait freeze with a timeout that forces
// release and sets a sticky error flag. Optional macro HAZARD_PERF_EN adds
// saturating stall and flush counters.
module pipeline_hazard_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic            clk,
  input  logic            reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;

  logic uses_rs1, uses_rs2;
  logic load_use;
  logic freeze;

  hazard_reg_use u_reg_use (
    .opcode_i   (hz.id_opcode),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2)
  );

  // Detect a load in EX whose result the ID instruction needs next cycle
  always_comb begin
    load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
               ((uses_rs1 && (hz.ex_rd == hz.id_rs1)) ||
                (uses_rs2 && (hz.ex_rd == hz.id_rs2)));
  end

  // Hold the pipeline while memory is busy, but not in the release cycle
  always_comb begin
    freeze = 1'b0;
    if (state_q == HZ_RUN) begin
      freeze = hz.mem_req && !hz.mem_ready;
    end else begin
      freeze = !hz.mem_ready && (wait_cnt_q < TIMEOUT_C);
    end
  end

  // Memory-wait FSM next state, wait counter and sticky error
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      HZ_RUN: begin
        if (hz.mem_req && !hz.mem_ready) begin
          state_d    = HZ_MEM_WAIT;
          wait_cnt_d = CNT_ONE;
        end
      end
      HZ_MEM_WAIT: begin
        if (hz.mem_ready) begin
          state_d    = HZ_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q < TIMEOUT_C) begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end else begin
          state_d    = HZ_RUN;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end
      end
      default: begin
        state_d    = HZ_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Stage enables and flushes by priority: reset, freeze, branch, load-use
  always_comb begin
    hz.pc_write     = 1'b1;
    hz.if_id_write  = 1'b1;
    hz.id_ex_write  = 1'b1;
    hz.ex_mem_write = 1'b1;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_flush  = 1'b0;
    hz.mem_wb_flush = 1'b0;
    if (reset) begin
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.id_ex_write  = 1'b0;
      hz.ex_mem_write = 1'b0;
      hz.if_id_flush  = 1'b1;
      hz.id_ex_flush  = 1'b1;
      hz.mem_wb_flush = 1'b1;
    end else if (freeze) begin
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.id_ex_write  = 1'b0;
      hz.ex_mem_write = 1'b0;
      hz.mem_wb_flush = 1'b1;
    end else if (hz.ex_branch_taken) begin
      hz.if_id_flush  = 1'b1;
      hz.id_ex_flush  = 1'b1;
    end else if (load_use) begin
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.id_ex_flush  = 1'b1;
    end
  end

  assign hz.mem_err = mem_err_q;

  // FSM state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HZ_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_flush_q, perf_flush_d;

  // Saturating counters of stall cycles and applied branch flushes
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if ((freeze || load_use) && (perf_stall_q != 16'hFFFF)) begin
      perf_stall_d = perf_stall_q + 16'd1;
    end
    if (hz.ex_branch_taken && !freeze && (perf_flush_q != 16'hFFFF)) begin
      perf_flush_d = perf_flush_q + 16'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign hz.perf_stall_cycles = perf_stall_q;
  assign hz.perf_flushes      = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (MEM_TIMEOUT=4). Inputs are
// driven 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_pipeline_hazard_ctrl;
  import ctrl_pkg::*;

  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;

  pipeline_hazard_ctrl_if hzBus ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hzBus.slave)
  );

  // Expected output vectors:
  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
  //  ex_mem_write, mem_wb_flush, mem_err}
  localparam logic [7:0] V_RESET = 8'b0010_1010;
  localparam logic [7:0] V_DEF   = 8'b1101_0100;
  localparam logic [7:0] V_FRZ   = 8'b0000_0010;
  localparam logic [7:0] V_BR    = 8'b1111_1100;
  localparam logic [7:0] V_LU    = 8'b0001_1100;
  localparam logic [7:0] V_ERR   = 8'b0000_0001;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [6:0] opcode, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] exRd,
                               input logic memRead, input logic branch,
                               input logic memReq, input logic memReady);
    hzBus.id_opcode       = opcode;
    hzBus.id_rs1          = rs1;
    hzBus.id_rs2          = rs2;
    hzBus.ex_rd           = exRd;
    hzBus.ex_mem_read     = memRead;
    hzBus.ex_branch_taken = branch;
    hzBus.mem_req         = memReq;
    hzBus.mem_ready       = memReady;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expected);
    logic [7:0] observed;
    @(negedge clk);
    observed = {hzBus.pc_write, hzBus.if_id_write, hzBus.if_id_flush,
                hzBus.id_ex_write, hzBus.id_ex_flush, hzBus.ex_mem_write,
                hzBus.mem_wb_flush, hzBus.mem_err};
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [0:0] expState,
                            input logic [7:0] expCnt);
    assertCount++;
    assert ((dut.state_q === expState) && (dut.wait_cnt_q === expCnt)) else begin
      failCount++;
      $error("[TB] FAIL %s observed state=%b cnt=%0d expected state=%b cnt=%0d",
             tag, dut.state_q, dut.wait_cnt_q, expState, expCnt);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    applyStimulus(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_outputs", V_RESET);
    nextCycle();
    reset = 1'b0;
    checkState("reset_state", HZ_RUN, 8'd0);

    $display("[TB] idle defaults");
    checkOutput("idle_default", V_DEF);
    nextCycle();

    $display("[TB] load-use: ld x5 in EX, add x6,x5,x1 in ID");
    applyStimulus(OP_RTYPE, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rtype_rs1", V_LU);
    nextCycle();
    applyStimulus(OP_RTYPE, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_bubble_done", V_DEF);
    nextCycle();

    $display("[TB] load-use register-use variants");
    applyStimulus(OP_SD, 5'd2, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_sd_rs2", V_LU);
    nextCycle();
    applyStimulus(OP_BEQ, 5'd3, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_beq_rs2", V_LU);
    nextCycle();
    applyStimulus(OP_LD, 5'd4, 5'd8, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_ld_rs1", V_LU);
    nextCycle();
    applyStimulus(OP_LD, 5'd4, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("ld_rs2_unused", V_DEF);
    nextCycle();
    applyStimulus(7'b0000000, 5'd6, 5'd6, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("unknown_op_no_lu", V_DEF);
    nextCycle();
    applyStimulus(OP_RTYPE, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("no_load_no_lu", V_DEF);
    nextCycle();

    $display("[TB] no stall for x0 or jal");
    applyStimulus(OP_RTYPE, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_x0_ignored", V_DEF);
    nextCycle();
    applyStimulus(OP_JAL, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("jal_no_lu", V_DEF);
    nextCycle();

    $display("[TB] branch over load-use");
    applyStimulus(OP_RTYPE, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("branch_beats_lu", V_BR);
    nextCycle();
    applyStimulus(OP_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("branch_alone", V_BR);
    nextCycle();

    $display("[TB] zero-wait memory access");
    applyStimulus(OP_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mem_zero_wait", V_DEF);
    nextCycle();
    checkState("zero_wait_state", HZ_RUN, 8'd0);

    $display("[TB] memory wait 3 cycles then ready");
    applyStimulus(OP_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("wait_c1", V_FRZ);
    nextCycle();
    checkState("wait_state_c2", HZ_MEM_WAIT, 8'd1);
    applyStimulus(OP_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("wait_c2_branch_held", V_FRZ);
    nextCycle();
    applyStimulus(OP_RTYPE, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("wait_c3_lu_held", V_FRZ);
    nextCycle();
    applyStimulus(OP_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("wait_release", V_DEF);
    nextCycle();
    applyStimulus(OP_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    checkState("after_release_state", HZ_RUN, 8'd0);
    checkOutput("after_release", V_DEF);
    nextCycle();

    $display("[TB] release cycle applies pending branch");
    applyStimulus(OP_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("wait2_c1", V_FRZ);
    nextCycle();
    applyStimulus(OP_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("release_with_branch", V_BR);
    nextCycle();

    $display("[TB] memory timeout");
    applyStimulus(OP_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("to_c1", V_FRZ);
    nextCycle();
    checkOutput("to_c2", V_FRZ);
    nextCycle();
    checkOutput("to_c3", V_FRZ);
    nextCycle();
    checkOutput("to_c4", V_FRZ);
    nextCycle();
    checkState("to_saturated_cnt", HZ_MEM_WAIT, 8'd4);
    checkOutput("to_forced_release", V_DEF);
    nextCycle();
    checkState("to_back_to_run", HZ_RUN, 8'd0);
    checkOutput("to_err_sticky_refreeze", V_FRZ | V_ERR);
    nextCycle();
    checkState("to_wait_again", HZ_MEM_WAIT, 8'd1);

    $display("[TB] reset while in MEM_WAIT");
    reset = 1'b1;
    checkOutput("reset_in_wait", V_RESET | V_ERR);
    nextCycle();
    reset = 1'b0;
    applyStimulus(OP_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    checkState("reset_wait_state", HZ_RUN, 8'd0);
    checkOutput("reset_clears_err", V_DEF);
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage 8-bit RISC-V pipeline (IF/ID/EX/MEM/WB).
- Detects load-use hazards in ID and applies the EX-resolved branch/jal redirect.
- Freezes the whole pipeline while data memory is not ready, through a wait FSM with timeout.
- Drives the write-enable and flush inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. The main decoder and forwarding unit are untouched.

Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles for one memory access before forced release; legal range 1..255.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- id_opcode  input  7  opcode of the instruction in ID.
- id_rs1  input  5  rs1 field in ID.
- id_rs2  input  5  rs2 field in ID.
- ex_rd  input  5  destination register in EX.
- ex_mem_read  input  1  EX instruction is a load.
- ex_branch_taken  input  1  beq taken or jal in EX; PC-target mux already selected.
- mem_req  input  1  MEM stage holds a load or store.
- mem_ready  input  1  data memory completes the access this cycle.
- pc_write  output  1  PC load enable.
- if_id_write  output  1  IF/ID enable.
- if_id_flush  output  1  zero IF/ID.
- id_ex_write  output  1  ID/EX enable.
- id_ex_flush  output  1  insert bubble into ID/EX.
- ex_mem_write  output  1  EX/MEM enable.
- mem_wb_flush  output  1  insert bubble into MEM/WB.
- mem_err  output  1  sticky flag: a memory timeout occurred.

Behaviour:
- States: RUN, MEM_WAIT. Registered: state, wait_cnt[CNT_W-1:0], mem_err. All other outputs are combinational from state and inputs.
- Reset cycle: state=RUN, wait_cnt=0, mem_err=0.
  - During reset: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_write=0, if_id_flush=1, id_ex_flush=1, mem_wb_flush=1.
  - Reset mid-MEM_WAIT returns to RUN next cycle with no error.
- Default (no event): all writes=1, all flushes=0.
- Register use:
  - uses_rs1 is true for every opcode except jal (1101111).
  - uses_rs2 is true for R-format (0110011), sd (0100011) and beq (1100011).
  - Unknown opcodes use neither register.
- load_use is true when all hold:
  - ex_mem_read=1 and ex_rd!=0;
  - (uses_rs1 and ex_rd==id_rs1) or (uses_rs2 and ex_rd==id_rs2).
- freeze is true in either case:
  - state=RUN and mem_req=1 and mem_ready=0;
  - state=MEM_WAIT and mem_ready=0 and wait_cnt<MEM_TIMEOUT.
- Priority, highest first:
  1. freeze: pc_write=if_id_write=id_ex_write=ex_mem_write=0; mem_wb_flush=1; other flushes=0. Branch and load-use are deferred because the EX/ID contents are held.
  2. ex_branch_taken: pc_write=1; if_id_flush=1; id_ex_flush=1. This overrides load_use in the same cycle, since the stalled instruction is squashed.
  3. load_use: pc_write=0; if_id_write=0; id_ex_flush=1. The bubble lasts exactly 1 cycle, because the load leaves EX.
- Transitions:
  - RUN → MEM_WAIT when mem_req=1 and mem_ready=0; wait_cnt←1.
  - MEM_WAIT with mem_ready=0 and wait_cnt<MEM_TIMEOUT: stay; wait_cnt+1.
  - MEM_WAIT with mem_ready=1: → RUN; wait_cnt←0; freeze deasserted in that same cycle (release cycle). A branch or load-use present then is applied normally.
  - MEM_WAIT with wait_cnt==MEM_TIMEOUT and mem_ready=0: → RUN; mem_err←1; no freeze this cycle (forced release; the access result is undefined).
- mem_req with mem_ready=1 in RUN: zero-wait access, no stall.
- mem_err clears only on reset.
- wait_cnt never wraps: it saturates at MEM_TIMEOUT.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cycles[15:0] and perf_flushes[15:0], both reset to 0.
  - perf_stall_cycles increments on every cycle with freeze or load_use.
  - perf_flushes increments on every ex_branch_taken that is not frozen.
  - Both counters saturate at 0xFFFF.
- Undefined: the ports and the counters do not exist.

Decomposition:
- Shared package ctrl_pkg:
  - opcode constants OP_RTYPE, OP_LD, OP_SD, OP_BEQ, OP_JAL (also to be used by the main decoder);
  - state encoding HZ_RUN=1'b0, HZ_MEM_WAIT=1'b1.
- One sub-module, hazard_reg_use: a combinational opcode → {uses_rs1, uses_rs2} lookup, reused by the forwarding unit.

Test Plan:
1. ld x5 in EX (ex_mem_read=1, ex_rd=5); add x6,x5,x1 in ID → exactly one cycle of pc_write=0, if_id_write=0, id_ex_flush=1, then defaults.
2. Load-use with ex_rd=0, and jal in ID with id_rs1 matching ex_rd → no stall.
3. ex_branch_taken=1 together with load_use=1 → pc_write=1, if_id_flush=1, id_ex_flush=1, if_id_write=1.
4. mem_req=1, mem_ready low for 3 cycles then high → freeze for 3 cycles with mem_wb_flush=1, release on the 4th cycle, state back to RUN, mem_err=0.
5. mem_ready held low, MEM_TIMEOUT=4 → freeze for 4 cycles, forced release on the 5th, mem_err=1 until reset. Then reset asserted in MEM_WAIT → RUN and mem_err=0 after one clk.
